// File: rtl/performance_event_counters.sv
// Bank of independent per-event counters: counter k advances by one on every cycle its event bit is high.
// Optional build macro PERFORMANCE_EVENT_COUNTERS_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module performance_event_counters #(
    parameter int INPUT_EVENT_BITMAP_WIDTH = 115,
    parameter int COUNTER_WIDTH            = 7
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [INPUT_EVENT_BITMAP_WIDTH-1:0]               performance_events,
    output logic [INPUT_EVENT_BITMAP_WIDTH*COUNTER_WIDTH-1:0] counters
);

    localparam int TOTAL_W = INPUT_EVENT_BITMAP_WIDTH * COUNTER_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    logic [TOTAL_W-1:0] r_counters;
    logic [TOTAL_W-1:0] w_next_counters;

    // Next value of a single counter; only the overflow rule differs between builds.
    function automatic logic [COUNTER_WIDTH-1:0] f_next_count(
        input logic [COUNTER_WIDTH-1:0] cur,
        input logic                     event_hit
    );
        if (!event_hit) begin
            f_next_count = cur;
`ifdef PERFORMANCE_EVENT_COUNTERS_SATURATE_EN
        end else if (&cur) begin
            f_next_count = cur;
`endif
        end else begin
            f_next_count = cur + CNT_ONE;
        end
    endfunction

    // Compute the next value of every counter in parallel.
    always_comb begin
        w_next_counters = r_counters;
        for (int k = 0; k < INPUT_EVENT_BITMAP_WIDTH; k++) begin
            w_next_counters[k*COUNTER_WIDTH +: COUNTER_WIDTH] =
                f_next_count(r_counters[k*COUNTER_WIDTH +: COUNTER_WIDTH], performance_events[k]);
        end
    end

    // Counter state register; reset clears all counters immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counters <= '0;
        end else begin
            r_counters <= w_next_counters;
        end
    end

    assign counters = r_counters;

endmodule

// File: tb/tb_performance_event_counters.sv
// Scoreboard bench for performance_event_counters: stimulus queues hand-computed expectations, monitor compares.
module tb_performance_event_counters;

    localparam int N = 115;
    localparam int W = 7;

    typedef struct {
        string          name;
        logic [N*W-1:0] vec;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   performance_events = '0;
    logic [N*W-1:0] counters;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    performance_event_counters #(
        .INPUT_EVENT_BITMAP_WIDTH(N),
        .COUNTER_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .performance_events(performance_events),
        .counters(counters)
    );

    always #5 clk = ~clk;

    // Build an expected counter vector: counters 0,1,2 given, all others crest.
    function automatic logic [N*W-1:0] mk(input int c0, input int c1, input int c2, input int crest);
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (k == 0)      v[k*W +: W] = W'(c0);
            else if (k == 1) v[k*W +: W] = W'(c1);
            else if (k == 2) v[k*W +: W] = W'(c2);
            else             v[k*W +: W] = W'(crest);
        end
        return v;
    endfunction

    // Drive events before the next rising edge and queue the value expected right after it.
    task automatic step(input logic [N-1:0] ev, input logic [N*W-1:0] expv, input string nm);
        exp_t e;
        @(negedge clk);
        performance_events = ev;
        e.name = nm;
        e.vec  = expv;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        performance_events = '0;
    endtask

    // Assert reset between edges, check the immediate clear, hold it with events high, then release.
    task automatic do_reset();
        exp_t e;
        idle();
        #2;
        e.name = "async_clear";
        e.vec  = mk(0, 0, 0, 0);
        q.push_back(e);
        rst_n = 1'b0;
        step('1, mk(0, 0, 0, 0), "rst_ignore");
        step('1, mk(0, 0, 0, 0), "rst_ignore");
        idle();
        rst_n = 1'b1;
    endtask

    // Monitor: output is valid on every clock edge and on reset assertion.
    initial begin
        exp_t e;
        int   bad;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (counters !== e.vec) begin
                    n_errors++;
                    bad = 0;
                    for (int k = N - 1; k >= 0; k--) begin
                        if (counters[k*W +: W] !== e.vec[k*W +: W]) bad = k;
                    end
                    $display("FAIL %s counter %0d got %0d expected %0d", e.name, bad,
                             counters[bad*W +: W], e.vec[bad*W +: W]);
                end
            end
        end
    end

    initial begin
        int expw;
        int waited;
        // Reset state, with events ignored while reset is held.
        step('1, mk(0, 0, 0, 0), "reset_state");
        step('1, mk(0, 0, 0, 0), "reset_state");
        idle();
        rst_n = 1'b1;

        // Steady stream on bit 0.
        for (int i = 1; i <= 14; i++) step(N'(1), mk(i, 0, 0, 0), "stream");

        // Reset mid-operation, then release with an event on the first edge.
        idle();
        #2;
        begin
            exp_t e;
            e.name = "mid_async_clear";
            e.vec  = mk(0, 0, 0, 0);
            q.push_back(e);
        end
        rst_n = 1'b0;
        step('1, mk(0, 0, 0, 0), "mid_rst_ignore");
        step('1, mk(0, 0, 0, 0), "mid_rst_ignore");
        begin
            exp_t e;
            @(negedge clk);
            rst_n = 1'b1;
            performance_events = N'(1);
            e.name = "release_first_edge";
            e.vec  = mk(1, 0, 0, 0);
            q.push_back(e);
        end
        for (int i = 2; i <= 5; i++) step(N'(1), mk(i, 0, 0, 0), "after_release");

        // Mixed bits.
        do_reset();
        step(N'(3'b001), mk(1, 0, 0, 0), "mixed1");
        step(N'(3'b101), mk(2, 0, 1, 0), "mixed2");
        step(N'(3'b001), mk(3, 0, 1, 0), "mixed3");
        step(N'(3'b011), mk(4, 1, 1, 0), "mixed4");
        step(N'(3'b101), mk(5, 1, 2, 0), "mixed5");
        idle();
        step('0, mk(5, 1, 2, 0), "mixed_hold");

        // All bits simultaneously.
        do_reset();
        for (int i = 1; i <= 3; i++) step('1, mk(i, i, i, i), "all_bits");
        idle();
        step('0, mk(3, 3, 3, 3), "all_bits_hold");

        // Overflow on bit 0.
        do_reset();
        for (int i = 1; i <= 130; i++) begin
`ifdef PERFORMANCE_EVENT_COUNTERS_SATURATE_EN
            expw = (i > 127) ? 127 : i;
`else
            expw = i % 128;
`endif
            step(N'(1), mk(expw, 0, 0, 0), "overflow");
        end
        idle();
`ifdef PERFORMANCE_EVENT_COUNTERS_SATURATE_EN
        step('0, mk(127, 0, 0, 0), "overflow_hold");
`else
        step('0, mk(2, 0, 0, 0), "overflow_hold");
`endif
        idle();

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
